// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 mouse host controller.
// The state encoding and the command/response bytes of the init exchange live here.
package ps2_pkg;

  typedef enum logic [3:0] {
    SEND_RST,
    WAIT_TX1,
    WAIT_ACK1,
    WAIT_BAT,
    WAIT_ID,
    SEND_EN,
    WAIT_TX2,
    WAIT_ACK2,
    STREAM,
    FAIL
  } state_t;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR = 8'hFC;
  localparam logic [7:0] RSP_ID      = 8'h00;

  // States in which the response timeout counter runs.
  function automatic logic is_wait(input state_t s);
    return (s == WAIT_TX1) || (s == WAIT_ACK1) || (s == WAIT_BAT) ||
           (s == WAIT_ID)  || (s == WAIT_TX2)  || (s == WAIT_ACK2);
  endfunction

endpackage

// File: rtl/ps2_mouse_init_seq_if.sv
// Byte link to the PS/2 transceiver plus the status/packet outputs of the controller.
// master = controller side, slave = transceiver/decoder side.
interface ps2_mouse_init_seq_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_done;
  logic        tx_err;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        streaming;
  logic        init_err;
  logic [1:0]  retry_cnt;
  logic [23:0] pkt;
  logic        pkt_valid;

  modport master (
    input  rx_data, rx_valid, tx_done, tx_err,
    output tx_data, tx_start, streaming, init_err, retry_cnt, pkt, pkt_valid
  );

  modport slave (
    output rx_data, rx_valid, tx_done, tx_err,
    input  tx_data, tx_start, streaming, init_err, retry_cnt, pkt, pkt_valid
  );

endinterface

// File: rtl/ps2_pkt_framer.sv
// Groups streamed mouse bytes into 3-byte movement packets, resyncing on bit 3 of
// the first byte and dropping a partial packet when the inter-byte gap expires.
module ps2_pkt_framer #(
  parameter int GAP_CYCLES = 100_000,
  parameter int CW         = 26
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_en,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [23:0] o_pkt,
  output logic        o_pkt_valid
);

  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  logic [1:0]    r_idx;
  logic [7:0]    r_byte0;
  logic [7:0]    r_byte1;
  logic [CW-1:0] r_gap;
  logic [23:0]   r_pkt;
  logic          r_pkt_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx       <= '0;
      r_byte0     <= '0;
      r_byte1     <= '0;
      r_gap       <= '0;
      r_pkt       <= '0;
      r_pkt_valid <= 1'b0;
    end else begin
      r_pkt_valid <= 1'b0;
      if (!i_en) begin
        r_idx <= '0;
        r_gap <= '0;
      end else if (i_rx_valid) begin
        r_gap <= '0;
        case (r_idx)
          2'd0: begin
            // A first byte always carries bit 3 set; anything else is mid-packet debris.
            if (i_rx_data[3]) begin
              r_byte0 <= i_rx_data;
              r_idx   <= 2'd1;
            end
          end
          2'd1: begin
            r_byte1 <= i_rx_data;
            r_idx   <= 2'd2;
          end
          default: begin
            r_pkt       <= {i_rx_data, r_byte1, r_byte0};
            r_pkt_valid <= 1'b1;
            r_idx       <= 2'd0;
          end
        endcase
      end else if (r_idx != 2'd0) begin
        if (r_gap == GAP_LAST) begin
          r_idx <= '0;
          r_gap <= '0;
        end else begin
          r_gap <= r_gap + 1'b1;
        end
      end
    end
  end

  assign o_pkt       = r_pkt;
  assign o_pkt_valid = r_pkt_valid;

endmodule

// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse host controller: reset/self-test/enable command exchange with timeout
// and retries, then hands the byte stream to the packet framer.
module ps2_mouse_init_seq
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int GAP_CYCLES     = 100_000,
  parameter int MAX_RETRIES    = 3,
  parameter int CW             = 26
) (
  input  logic                 CLK,
  input  logic                 RST,
  ps2_mouse_init_seq_if.master bus
);

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_tmo;
  logic [1:0]    r_retry;
  logic [1:0]    w_retry_next;
  logic          r_tx_start;
  logic [7:0]    r_tx_data;
  logic          w_send;
  logic [7:0]    w_cmd;
  logic          w_fail;
  logic          w_wait;
  logic          w_streaming;
  logic [23:0]   w_pkt;
  logic          w_pkt_valid;

  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    w_send       = 1'b0;
    w_cmd        = CMD_RESET;
    w_fail       = 1'b0;
    w_wait       = is_wait(r_state);
    case (r_state)
      SEND_RST: begin
        w_send       = 1'b1;
        w_cmd        = CMD_RESET;
        w_state_next = WAIT_TX1;
      end
      WAIT_TX1, WAIT_TX2: begin
        if (bus.tx_err)       w_fail = 1'b1;
        else if (bus.tx_done) w_state_next = (r_state == WAIT_TX1) ? WAIT_ACK1 : WAIT_ACK2;
      end
      WAIT_ACK1: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == RSP_ACK) w_state_next = WAIT_BAT;
          else                        w_fail = 1'b1;
        end
      end
      WAIT_BAT: begin
        // Other bytes can precede the self-test result; only the two verdicts matter.
        if (bus.rx_valid) begin
          if (bus.rx_data == RSP_BAT_OK)       w_state_next = WAIT_ID;
          else if (bus.rx_data == RSP_BAT_ERR) w_fail = 1'b1;
        end
      end
      WAIT_ID: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == RSP_ID) w_state_next = SEND_EN;
          else                       w_fail = 1'b1;
        end
      end
      SEND_EN: begin
        w_send       = 1'b1;
        w_cmd        = CMD_ENABLE;
        w_state_next = WAIT_TX2;
      end
      WAIT_ACK2: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == RSP_ACK) w_state_next = STREAM;
          else                        w_fail = 1'b1;
        end
      end
      STREAM:  w_state_next = STREAM;
      FAIL:    w_state_next = FAIL;
      default: w_state_next = SEND_RST;
    endcase

    if (w_wait && !w_fail && (w_state_next == r_state) && !bus.rx_valid && (r_tmo == TMO_LAST))
      w_fail = 1'b1;

    if (w_fail) begin
      w_retry_next = (r_retry == 2'd3) ? r_retry : r_retry + 2'd1;
      w_state_next = ((int'(r_retry) + 1) >= MAX_RETRIES) ? FAIL : SEND_RST;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= SEND_RST;
      r_tmo      <= '0;
      r_retry    <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_retry    <= w_retry_next;
      r_tx_start <= w_send;
      if (w_send) r_tx_data <= w_cmd;
      if ((w_state_next != r_state) || bus.rx_valid) r_tmo <= '0;
      else if (w_wait)                               r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_streaming   = (r_state == STREAM);
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_start  = r_tx_start;
  assign bus.streaming = w_streaming;
  assign bus.init_err  = (r_state == FAIL);
  assign bus.retry_cnt = r_retry;
  assign bus.pkt       = w_pkt;
  assign bus.pkt_valid = w_pkt_valid;

  ps2_pkt_framer #(
    .GAP_CYCLES (GAP_CYCLES),
    .CW         (CW)
  ) u_framer (
    .CLK         (CLK),
    .RST         (RST),
    .i_en        (w_streaming),
    .i_rx_data   (bus.rx_data),
    .i_rx_valid  (bus.rx_valid),
    .o_pkt       (w_pkt),
    .o_pkt_valid (w_pkt_valid)
  );

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Directed bench for ps2_mouse_init_seq: init exchange, framing, retries, exhaustion, reset.
module tb_ps2_mouse_init_seq;
  import ps2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_mouse_init_seq_if bus();

  ps2_mouse_init_seq #(
    .TIMEOUT_CYCLES (200),
    .GAP_CYCLES     (50),
    .MAX_RETRIES    (3),
    .CW             (26)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_start = 0;
  int n_pv    = 0;

  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) n_start++;
    if (bus.pkt_valid === 1'b1) n_pv++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse(input logic done, input logic err);
    bus.tx_done = done;
    bus.tx_err  = err;
    @(posedge clk); #1;
    bus.tx_done = 1'b0;
    bus.tx_err  = 1'b0;
  endtask

  task automatic expect_cmd(input string tag, input logic [7:0] cmd, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) chk({tag, "_data"}, 32'(bus.tx_data), 32'(cmd));
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tx_start"},  32'(bus.tx_start),  32'd0);
    chk({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
    chk({tag, "_streaming"}, 32'(bus.streaming), 32'd0);
    chk({tag, "_init_err"},  32'(bus.init_err),  32'd0);
    chk({tag, "_retry"},     32'(bus.retry_cnt), 32'd0);
    chk({tag, "_pkt"},       32'(bus.pkt),       32'd0);
    chk({tag, "_pkt_valid"}, 32'(bus.pkt_valid), 32'd0);
  endtask

  // Release reset; the reset command must appear exactly one cycle later.
  task automatic release_rst(input string tag);
    rst = 1'b0;
    @(negedge clk);
    chk({tag, "_no_early_start"}, 32'(bus.tx_start), 32'd0);
    @(negedge clk);
    chk({tag, "_first_start"}, 32'(bus.tx_start), 32'd1);
    chk({tag, "_first_cmd"},   32'(bus.tx_data),  32'hFF);
    @(posedge clk); #1;
  endtask

  task automatic finish_init(input string tag);
    pulse(1'b1, 1'b0);
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    expect_cmd({tag, "_enable"}, 8'hF4, 10);
    pulse(1'b1, 1'b0);
    send_rx(8'hFA);
    chk({tag, "_streaming"}, 32'(bus.streaming), 32'd1);
  endtask

  initial begin
    int s0;
    int p0;
    bit seen;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_done  = 1'b0;
    bus.tx_err   = 1'b0;

    // Reset state
    tick(3);
    check_idle("reset");

    // Nominal init
    s0 = n_start;
    release_rst("nom");
    finish_init("nom");
    chk("nom_retry", 32'(bus.retry_cnt), 32'd0);
    chk("nom_init_err", 32'(bus.init_err), 32'd0);
    tick(5);
    chk("nom_start_count", 32'(n_start - s0), 32'd2);

    // Packet with a leading resync discard
    p0 = n_pv;
    send_rx(8'h01);
    send_rx(8'h09);
    send_rx(8'h05);
    send_rx(8'hFB);
    chk("pkt_valid_pulse", 32'(bus.pkt_valid), 32'd1);
    chk("pkt_value", 32'(bus.pkt), 32'h00FB0509);
    tick(1);
    chk("pkt_valid_one_cycle", 32'(bus.pkt_valid), 32'd0);
    tick(3);
    chk("pkt_strobe_count", 32'(n_pv - p0), 32'd1);
    chk("pkt_hold", 32'(bus.pkt), 32'h00FB0509);

    // Gap resync drops the partial packet
    p0 = n_pv;
    send_rx(8'h08);
    tick(60);
    send_rx(8'h18);
    send_rx(8'h01);
    send_rx(8'h02);
    tick(2);
    chk("gap_pkt_value", 32'(bus.pkt), 32'h00020118);
    chk("gap_strobe_count", 32'(n_pv - p0), 32'd1);

    // Bad self-test result triggers a retry
    rst = 1'b1;
    tick(2);
    check_idle("rst_stream");
    s0 = n_start;
    release_rst("bat");
    pulse(1'b1, 1'b0);
    send_rx(8'hFA);
    send_rx(8'hFC);
    chk("bat_retry", 32'(bus.retry_cnt), 32'd1);
    expect_cmd("bat_reissue", 8'hFF, 10);
    finish_init("bat");
    chk("bat_retry_kept", 32'(bus.retry_cnt), 32'd1);
    chk("bat_start_count", 32'(n_start - s0), 32'd3);

    // Exhaustion: no response after tx_done, three timeouts
    rst = 1'b1;
    tick(2);
    s0 = n_start;
    release_rst("exh");
    pulse(1'b1, 1'b0);
    tick(150);
    chk("exh_no_early_timeout", 32'(bus.retry_cnt), 32'd0);
    for (int k = 0; k < 2; k++) begin
      expect_cmd("exh_retry", 8'hFF, 400);
      pulse(1'b1, 1'b0);
    end
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.init_err === 1'b1) seen = 1'b1;
    end
    chk("exh_init_err", 32'(seen), 32'd1);
    chk("exh_retry_cnt", 32'(bus.retry_cnt), 32'd3);
    chk("exh_streaming", 32'(bus.streaming), 32'd0);
    tick(300);
    chk("exh_start_count", 32'(n_start - s0), 32'd3);
    chk("exh_still_failed", 32'(bus.init_err), 32'd1);

    // Simultaneous tx_done/tx_err, then reset from WAIT_ACK2
    rst = 1'b1;
    tick(2);
    release_rst("both");
    pulse(1'b1, 1'b1);
    chk("both_err_wins", 32'(bus.retry_cnt), 32'd1);
    expect_cmd("both_reissue", 8'hFF, 10);
    pulse(1'b1, 1'b0);
    send_rx(8'hFA);
    send_rx(8'hAA);
    send_rx(8'h00);
    expect_cmd("ack2_enable", 8'hF4, 10);
    pulse(1'b1, 1'b0);
    chk("ack2_not_streaming", 32'(bus.streaming), 32'd0);
    chk("ack2_retry", 32'(bus.retry_cnt), 32'd1);
    rst = 1'b1;
    tick(2);
    check_idle("rst_ack2");
    release_rst("ack2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
